// File: rtl/vec_lsu_if.sv
// Signal bundle between vec_lsu, the execute stage, data memory and vector RAM.
// master is the LSU side; slave is the execute/memory/RAM side.
interface vec_lsu_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int VEC_WORDS        = 8,
  parameter int ADDR_WIDTH       = 32,
  parameter int VREG_INDEX_WIDTH = 5
);
  logic                            i_start;
  logic                            i_op;
  logic [ADDR_WIDTH-1:0]           i_base;
  logic [ADDR_WIDTH-1:0]           i_stride;
  logic [VREG_INDEX_WIDTH-1:0]     i_vreg;
  logic                            o_busy;
  logic                            o_done;
  logic                            o_err;
  logic [ADDR_WIDTH-1:0]           o_addr;
  logic [DATA_WIDTH-1:0]           o_data;
  logic                            o_wr_valid;
  logic                            i_wr_ready;
  logic [2:0]                      o_wr_width;
  logic [DATA_WIDTH-1:0]           i_data;
  logic                            i_rd_valid;
  logic                            o_rd_ready;
  logic                            o_vram_we;
  logic [VREG_INDEX_WIDTH-1:0]     o_vram_waddr;
  logic [VEC_WORDS*DATA_WIDTH-1:0] o_vram_wdata;
  logic                            o_vram_re;
  logic [VREG_INDEX_WIDTH-1:0]     o_vram_raddr;
  logic [VEC_WORDS*DATA_WIDTH-1:0] i_vram_rdata;

  modport master (
    input  i_start, i_op, i_base, i_stride, i_vreg,
    input  i_wr_ready, i_data, i_rd_valid, i_vram_rdata,
    output o_busy, o_done, o_err, o_addr, o_data,
    output o_wr_valid, o_wr_width, o_rd_ready,
    output o_vram_we, o_vram_waddr, o_vram_wdata,
    output o_vram_re, o_vram_raddr
  );

  modport slave (
    output i_start, i_op, i_base, i_stride, i_vreg,
    output i_wr_ready, i_data, i_rd_valid, i_vram_rdata,
    input  o_busy, o_done, o_err, o_addr, o_data,
    input  o_wr_valid, o_wr_width, o_rd_ready,
    input  o_vram_we, o_vram_waddr, o_vram_wdata,
    input  o_vram_re, o_vram_raddr
  );
endinterface

// File: rtl/vec_lsu.sv
// Vector load/store unit: moves one vector register between memory and
// the vector register RAM using word beats at a base plus signed stride.
module vec_lsu #(
  parameter int DATA_WIDTH       = 32,
  parameter int VEC_WORDS        = 8,
  parameter int ADDR_WIDTH       = 32,
  parameter int VREG_INDEX_WIDTH = 5
) (
  input  logic      i_clk,
  input  logic      i_rst,
  vec_lsu_if.master bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BW    = $clog2(VEC_WORDS + 1);
  localparam int IW    = (VEC_WORDS > 1) ? $clog2(VEC_WORDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [BW-1:0]         LAST  = BW'(VEC_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LD, S_ST_RD, S_ST_CAP, S_ST, S_DONE
  } state_e;

  typedef logic [VEC_WORDS-1:0][DATA_WIDTH-1:0] vbuf_t;

  state_e                      state_q, state_d;
  logic [BW-1:0]               beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]       stride_q, stride_d;
  logic [VREG_INDEX_WIDTH-1:0] vreg_q, vreg_d;
  logic                        op_q, op_d;
  logic                        err_q, err_d;
  vbuf_t                       vbuf_q, vbuf_d;
  logic [IW-1:0]               idx;
  logic                        misal;

  assign idx   = beat_q[IW-1:0];
  assign misal = |((bus.i_base | bus.i_stride) & AMASK);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      vreg_q   <= '0;
      op_q     <= 1'b0;
      err_q    <= 1'b0;
      vbuf_q   <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      vreg_q   <= vreg_d;
      op_q     <= op_d;
      err_q    <= err_d;
      vbuf_q   <= vbuf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    vreg_d   = vreg_q;
    op_d     = op_q;
    err_d    = err_q;
    vbuf_d   = vbuf_q;

    bus.o_busy       = (state_q != S_IDLE);
    bus.o_done       = 1'b0;
    bus.o_err        = 1'b0;
    bus.o_addr       = '0;
    bus.o_data       = '0;
    bus.o_wr_valid   = 1'b0;
    bus.o_wr_width   = 3'd0;
    bus.o_rd_ready   = 1'b0;
    bus.o_vram_we    = 1'b0;
    bus.o_vram_waddr = '0;
    bus.o_vram_wdata = '0;
    bus.o_vram_re    = 1'b0;
    bus.o_vram_raddr = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          op_d     = bus.i_op;
          addr_d   = bus.i_base;
          stride_d = bus.i_stride;
          vreg_d   = bus.i_vreg;
          beat_d   = '0;
          err_d    = misal;
          // A misaligned command skips all traffic and reports at once
          if (misal)         state_d = S_DONE;
          else if (bus.i_op) state_d = S_ST_RD;
          else               state_d = S_LD;
        end
      end
      S_LD: begin
        bus.o_rd_ready = 1'b1;
        bus.o_addr     = addr_q;
        if (bus.i_rd_valid) begin
          vbuf_d[idx] = bus.i_data;
          beat_d      = beat_q + 1'b1;
          addr_d      = addr_q + stride_q;
          if (beat_q == LAST) state_d = S_DONE;
        end
      end
      S_ST_RD: begin
        bus.o_vram_re    = 1'b1;
        bus.o_vram_raddr = vreg_q;
        state_d          = S_ST_CAP;
      end
      S_ST_CAP: begin
        vbuf_d  = bus.i_vram_rdata;
        state_d = S_ST;
      end
      S_ST: begin
        bus.o_wr_valid = 1'b1;
        bus.o_wr_width = 3'(BYTES);
        bus.o_addr     = addr_q;
        bus.o_data     = vbuf_q[idx];
        if (bus.i_wr_ready) begin
          beat_d = beat_q + 1'b1;
          addr_d = addr_q + stride_q;
          if (beat_q == LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        bus.o_done = 1'b1;
        bus.o_err  = err_q;
        if (!op_q && !err_q) begin
          bus.o_vram_we    = 1'b1;
          bus.o_vram_waddr = vreg_q;
          bus.o_vram_wdata = vbuf_q;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_vec_lsu.sv
// Scoreboard bench for vec_lsu: stimulus pushes expected beats/completions,
// a monitor pops and compares them as the DUT presents them.
module tb_vec_lsu;
  localparam int DW = 32;
  localparam int VW = 8;
  localparam int AW = 32;
  localparam int RW = 5;
  localparam int VB = VW * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vec_lsu_if #(.DATA_WIDTH(DW), .VEC_WORDS(VW),
               .ADDR_WIDTH(AW), .VREG_INDEX_WIDTH(RW)) bus ();

  vec_lsu #(.DATA_WIDTH(DW), .VEC_WORDS(VW),
            .ADDR_WIDTH(AW), .VREG_INDEX_WIDTH(RW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    logic          err;
    logic          we;
    logic [RW-1:0] waddr;
    logic [VB-1:0] wdata;
    int            t0;
    int            lat;
  } done_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } st_t;

  done_t         exp_done[$];
  st_t           exp_st[$];
  logic [AW-1:0] exp_ld[$];
  logic [VB-1:0] mdl [32];
  logic [DW-1:0] ld_pat [VW];

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  int ndone_exp = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int mode = 0;
  bit phase;

  task automatic chk(input string nm, input logic [VB-1:0] act,
                     input logic [VB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm, input logic [AW-1:0] a);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event at addr %0h want none", nm, a);
  endtask

  // Memory and vector RAM models
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_vram_re) bus.i_vram_rdata <= mdl[bus.o_vram_raddr];
    if (rst || bus.o_done) rd_cnt <= 0;
    else if (bus.o_rd_ready && bus.i_rd_valid) rd_cnt <= rd_cnt + 1;
  end

  always @(negedge clk) begin
    phase = ~phase;
    case (mode)
      0: begin
        bus.i_rd_valid = 1'b1;
        bus.i_wr_ready = 1'b1;
      end
      1: begin
        bus.i_rd_valid = phase;
        bus.i_wr_ready = phase;
      end
      default: begin
        bus.i_rd_valid = 1'($urandom);
        bus.i_wr_ready = 1'($urandom);
      end
    endcase
    bus.i_data = ld_pat[3'(rd_cnt)];
  end

  // Monitor
  logic          pv, pr, prst;
  logic [AW-1:0] pa, ma;
  logic [DW-1:0] pd;
  done_t         me;
  st_t           ms;

  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (pv && !pr && !prst) begin
        chk("hold_valid", VB'(bus.o_wr_valid), VB'(1));
        chk("hold_addr", VB'(bus.o_addr), VB'(pa));
        chk("hold_data", VB'(bus.o_data), VB'(pd));
      end
      if (bus.o_wr_valid) chk("wr_width", VB'(bus.o_wr_width), VB'(4));
      if (bus.o_rd_ready && bus.i_rd_valid) begin
        if (exp_ld.size() == 0) bad("unexp_rd_beat", bus.o_addr);
        else begin
          ma = exp_ld.pop_front();
          chk("ld_addr", VB'(bus.o_addr), VB'(ma));
        end
      end
      if (bus.o_wr_valid && bus.i_wr_ready) begin
        if (exp_st.size() == 0) bad("unexp_wr_beat", bus.o_addr);
        else begin
          ms = exp_st.pop_front();
          chk("st_addr", VB'(bus.o_addr), VB'(ms.a));
          chk("st_data", VB'(bus.o_data), VB'(ms.d));
        end
      end
      if (bus.o_done) begin
        n_done++;
        if (exp_done.size() == 0) bad("unexp_done", bus.o_addr);
        else begin
          me = exp_done.pop_front();
          chk("done_err", VB'(bus.o_err), VB'(me.err));
          chk("done_we", VB'(bus.o_vram_we), VB'(me.we));
          if (me.we) begin
            chk("done_waddr", VB'(bus.o_vram_waddr), VB'(me.waddr));
            chk("done_wdata", bus.o_vram_wdata, me.wdata);
          end
          if (me.lat >= 0) chk("latency", VB'(cyc - me.t0), VB'(me.lat));
        end
      end else if (bus.o_vram_we) begin
        bad("unexp_vram_we", bus.o_addr);
      end
    end
    pv   = bus.o_wr_valid;
    pr   = bus.i_wr_ready;
    pa   = bus.o_addr;
    pd   = bus.o_data;
    prst = rst;
  end

  // Reference model: expected beats and completion of one command
  task automatic expect_cmd(input bit op, input logic [AW-1:0] base,
                            input logic [AW-1:0] stride,
                            input logic [RW-1:0] vr, input int m,
                            input bit keep);
    done_t e;
    st_t   s;
    bit    mis;
    mis = ((base | stride) & 32'h3) != 0;
    if (!mis) begin
      for (int k = 0; k < VW; k++) begin
        s.a = base + stride * AW'(k);
        s.d = mdl[vr][k*DW +: DW];
        if (op) exp_st.push_back(s);
        else    exp_ld.push_back(s.a);
      end
    end
    e.err   = mis;
    e.we    = !mis && !op;
    e.waddr = vr;
    e.wdata = '0;
    for (int k = 0; k < VW; k++) e.wdata[k*DW +: DW] = ld_pat[k];
    e.lat = (m != 0) ? -1 : mis ? 0 : op ? VW + 2 : VW;
    e.t0  = 0;
    if (keep) begin
      exp_done.push_back(e);
      ndone_exp++;
      if (e.we) mdl[vr] = e.wdata;
    end
  endtask

  task automatic start_cmd(input bit op, input logic [AW-1:0] base,
                           input logic [AW-1:0] stride,
                           input logic [RW-1:0] vr, input int m,
                           input bit keep, input bit hold);
    mode = m;
    expect_cmd(op, base, stride, vr, m, keep);
    @(negedge clk);
    bus.i_start  = 1'b1;
    bus.i_op     = op;
    bus.i_base   = base;
    bus.i_stride = stride;
    bus.i_vreg   = vr;
    @(posedge clk);
    #1;
    if (keep) exp_done[exp_done.size()-1].t0 = cyc;
    if (!hold) bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (n_done < target && t < 3000) begin
      @(posedge clk);
      t++;
    end
    n_vec++;
    if (n_done < target) begin
      n_err++;
      $display("FAIL done_timeout: got %0d dones want %0d", n_done, target);
      @(negedge clk);
      rst = 1'b1;
      bus.i_start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_ld.delete();
      exp_st.delete();
      exp_done.delete();
      n_done = target;
    end
  endtask

  task automatic issue(input bit op, input logic [AW-1:0] base,
                       input logic [AW-1:0] stride,
                       input logic [RW-1:0] vr, input int m);
    start_cmd(op, base, stride, vr, m, 1'b1, 1'b0);
    wait_done(ndone_exp);
  endtask

  initial begin
    bus.i_start  = 1'b0;
    bus.i_op     = 1'b0;
    bus.i_base   = '0;
    bus.i_stride = '0;
    bus.i_vreg   = '0;
    for (int r = 0; r < 32; r++)
      for (int k = 0; k < VW; k++) mdl[r][k*DW +: DW] = $urandom;
    for (int k = 0; k < VW; k++) ld_pat[k] = $urandom;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", VB'(bus.o_busy), '0);
    chk("rst_done", VB'(bus.o_done), '0);
    chk("rst_err", VB'(bus.o_err), '0);
    chk("rst_wr_valid", VB'(bus.o_wr_valid), '0);
    chk("rst_rd_ready", VB'(bus.o_rd_ready), '0);
    chk("rst_vram_we", VB'(bus.o_vram_we), '0);
    chk("rst_vram_re", VB'(bus.o_vram_re), '0);
    chk("rst_addr", VB'(bus.o_addr), '0);
    chk("rst_data", VB'(bus.o_data), '0);
    chk("rst_wr_width", VB'(bus.o_wr_width), '0);
    chk("rst_waddr", VB'(bus.o_vram_waddr), '0);
    chk("rst_raddr", VB'(bus.o_vram_raddr), '0);
    chk("rst_wdata", bus.o_vram_wdata, '0);
    rst = 1'b0;

    for (int k = 0; k < VW; k++) ld_pat[k] = 32'hA0 + DW'(k);
    issue(1'b0, 32'h100, 32'd4, 5'd3, 0);

    for (int k = 0; k < VW; k++) mdl[5][k*DW +: DW] = 32'h11 * DW'(k);
    issue(1'b1, 32'h40, 32'hFFFF_FFF8, 5'd5, 1);
    issue(1'b1, 32'h80, 32'd4, 5'd5, 0);

    issue(1'b0, 32'h102, 32'd4, 5'd1, 0);
    issue(1'b1, 32'h100, 32'd6, 5'd1, 0);

    for (int k = 0; k < VW; k++) ld_pat[k] = $urandom;
    start_cmd(1'b0, 32'h200, 32'd4, 5'd2, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rstmid_busy", VB'(bus.o_busy), '0);
    chk("rstmid_vram_we", VB'(bus.o_vram_we), '0);
    chk("rstmid_left", VB'(exp_ld.size()), VB'(VW - 3));
    exp_ld.delete();
    issue(1'b0, 32'h300, 32'd8, 5'd2, 0);

    for (int k = 0; k < VW; k++) ld_pat[k] = 32'h5000 + DW'(k);
    start_cmd(1'b0, 32'hFFFF_FFFC, 32'd0, 5'd7, 0, 1'b1, 1'b1);
    expect_cmd(1'b0, 32'hFFFF_FFF8, 32'd4, 5'd9, 0, 1'b1);
    @(negedge clk);
    bus.i_base   = 32'hFFFF_FFF8;
    bus.i_stride = 32'd4;
    bus.i_vreg   = 5'd9;
    wait_done(ndone_exp - 1);
    @(posedge clk);
    #1;
    if (exp_done.size() > 0) exp_done[exp_done.size()-1].t0 = cyc;
    bus.i_start = 1'b0;
    wait_done(ndone_exp);
    issue(1'b1, 32'h1000, 32'd4, 5'd9, 0);

    for (int i = 0; i < 30; i++) begin
      bit            op;
      logic [AW-1:0] b;
      logic [AW-1:0] s;
      op = 1'($urandom);
      b  = $urandom & ~32'h3;
      case ($urandom_range(0, 3))
        0:       s = '0;
        1:       s = AW'($urandom_range(1, 16)) * 4;
        2:       s = -(AW'($urandom_range(1, 16)) * 4);
        default: s = $urandom & ~32'h3;
      endcase
      if ($urandom_range(0, 7) == 0) b = b | AW'($urandom_range(1, 3));
      for (int k = 0; k < VW; k++) ld_pat[k] = $urandom;
      issue(op, b, s, RW'($urandom), $urandom_range(0, 2));
    end

    repeat (2) @(posedge clk);
    chk("queues_empty",
        VB'(exp_ld.size() + exp_st.size() + exp_done.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
